pspin_stdout_packer: RTL and testbench

- Collects per-core printf byte streams inside the PsPIN clock domain.
- Packs each stream into 32-bit tagged words and writes them into the stdout FIFO write port.
- The host drains that FIFO through the control-register block at 0x1000.
- Provides round-robin fairness, newline/idle flush, and backpressure toward cores; no data is ever dropped.

---
 rtl/pspin_stdout_packer.sv | 131 +++++++++++++
 tb/tb_pspin_stdout_packer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pspin_stdout_packer.sv
// Packs per-core printf byte streams into tagged 32-bit words
// and writes them round-robin into the stdout FIFO.
module pspin_stdout_packer #(
   parameter int         NUM_SRC = 4,
   parameter int         TIMEOUT = 1024,
   parameter logic [7:0] NEWLINE = 8'h0A
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_SRC-1:0]     src_valid,
   input  logic [8*NUM_SRC-1:0]   src_data,
   output logic [NUM_SRC-1:0]     src_ready,
   input  logic                   fifo_almost_full,
   input  logic                   fifo_wr_rst_busy,
   output logic                   fifo_wr_en,
   output logic [31:0]            fifo_din,
   output logic [31:0]            wr_count
);

   localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [IW-1:0] LAST_SRC = IW'(NUM_SRC - 1);

   logic [NUM_SRC-1:0] pending;
   logic [31:0]        word [NUM_SRC];
   logic [IW-1:0]      last_grant;
   logic [IW-1:0]      gnt_idx;
   logic               gnt_vld;

   assign src_ready = ~pending;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [1:0]    cnt;
      logic [23:0]   acc;
      logic [23:0]   acc_nxt;
      logic [TW-1:0] timer;
      logic [31:0]   word_q;
      logic          pend_q;
      logic [7:0]    byte_in;
      logic          accept;
      logic          seal_now;
      logic          idle_seal;

      assign byte_in   = src_data[8*i +: 8];
      assign accept    = src_valid[i] & ~pend_q;
      assign seal_now  = accept & ((cnt == 2'd2) | (byte_in == NEWLINE));
      assign idle_seal = ~accept & ~pend_q & (cnt != 2'd0)
                       & (timer == T_LAST);
      assign pending[i] = pend_q;
      assign word[i]    = word_q;

      always_comb begin
         acc_nxt = acc;
         case (cnt)
            2'd0:    acc_nxt[7:0]   = byte_in;
            2'd1:    acc_nxt[15:8]  = byte_in;
            default: acc_nxt[23:16] = byte_in;
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt    <= 2'd0;
            acc    <= '0;
            timer  <= '0;
            word_q <= '0;
            pend_q <= 1'b0;
         end else begin
            if (accept) begin
               timer <= '0;
               if (seal_now) begin
                  pend_q <= 1'b1;
                  word_q <= {6'(i), cnt + 2'd1, acc_nxt};
                  cnt    <= 2'd0;
                  acc    <= '0;
               end else begin
                  cnt <= cnt + 2'd1;
                  acc <= acc_nxt;
               end
            end else if (idle_seal) begin
               pend_q <= 1'b1;
               word_q <= {6'(i), cnt, acc};
               cnt    <= 2'd0;
               acc    <= '0;
               timer  <= '0;
            end else if (cnt != 2'd0 && !pend_q) begin
               timer <= timer + 1'b1;
            end
            // a pending source never accepts, so grant and seal are disjoint
            if (gnt_vld && gnt_idx == IW'(i))
               pend_q <= 1'b0;
         end
      end
   end

   always_comb begin
      int j;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      j       = 0;
      if (!fifo_almost_full && !fifo_wr_rst_busy) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            j = int'(last_grant) + 1 + k;
            if (j >= NUM_SRC)
               j = j - NUM_SRC;
            if (!gnt_vld && pending[IW'(j)]) begin
               gnt_vld = 1'b1;
               gnt_idx = IW'(j);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_wr_en <= 1'b0;
         fifo_din   <= '0;
         wr_count   <= '0;
         last_grant <= LAST_SRC;
      end else begin
         fifo_wr_en <= gnt_vld;
         if (gnt_vld) begin
            fifo_din   <= word[gnt_idx];
            last_grant <= gnt_idx;
            wr_count   <= wr_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_pspin_stdout_packer.sv
// Directed bench for pspin_stdout_packer: packing, flush,
// timeout, round-robin, backpressure and reset.
module tb_pspin_stdout_packer;

   localparam int N  = 4;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   src_valid = '0;
   logic [8*N-1:0] src_data = '0;
   logic [N-1:0]   src_ready;
   logic           fifo_almost_full = 1'b0;
   logic           fifo_wr_rst_busy = 1'b0;
   logic           fifo_wr_en;
   logic [31:0]    fifo_din;
   logic [31:0]    wr_count;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [31:0] wq [$];
   int          tq [$];

   pspin_stdout_packer #(
      .NUM_SRC (N),
      .TIMEOUT (TO),
      .NEWLINE (8'h0A)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .src_valid        (src_valid),
      .src_data         (src_data),
      .src_ready        (src_ready),
      .fifo_almost_full (fifo_almost_full),
      .fifo_wr_rst_busy (fifo_wr_rst_busy),
      .fifo_wr_en       (fifo_wr_en),
      .fifo_din         (fifo_din),
      .wr_count         (wr_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fifo_wr_en) begin
         wq.push_back(fifo_din);
         tq.push_back(cyc);
      end
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(int s, logic [7:0] b);
      src_valid[s] = 1'b1;
      src_data[8*s +: 8] = b;
      tick();
      src_valid = '0;
   endtask

   task automatic drive(logic [N-1:0] v, logic [8*N-1:0] d);
      src_valid = v;
      src_data = d;
      tick();
      src_valid = '0;
   endtask

   task automatic pull(string tag, logic [31:0] exp, output int t);
      int k = 0;
      while (wq.size() == 0 && k < 40) begin
         tick();
         k++;
      end
      if (wq.size() == 0) begin
         check({tag, "_timeout"}, 32'h0, exp);
         t = -1;
      end else begin
         check(tag, wq.pop_front(), exp);
         t = tq.pop_front();
      end
   endtask

   initial begin
      int t0, t1;
      int ts [N];
      logic [8*N-1:0] d;
      logic [7:0] b1, b2, b3;

      // reset state
      #2;
      check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check("rst_din", fifo_din, 32'h0);
      check("rst_count", wr_count, 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick();
      check("rst_ready", 32'(src_ready), 32'hF);

      // three bytes seal a full word
      send(0, 8'h61);
      send(0, 8'h62);
      send(0, 8'h63);
      check("seal_ready_lo", 32'(src_ready[0]), 32'd0);
      tick();
      check("grant_ready_hi", 32'(src_ready[0]), 32'd1);
      check("abc_wr_en", 32'(fifo_wr_en), 32'd1);
      check("abc_din", fifo_din, 32'h03636261);
      check("abc_count", wr_count, 32'd1);
      pull("abc_word", 32'h03636261, t0);

      // newline flushes
      send(0, 8'h68);
      send(0, 8'h69);
      send(0, 8'h0A);
      pull("hi_nl", 32'h030A6968, t0);
      send(0, 8'h7A);
      send(0, 8'h0A);
      pull("z_nl", 32'h02000A7A, t0);

      // idle timeout seals a single byte
      send(2, 8'h78);
      t0 = cyc;
      pull("to_word", 32'h09000078, t1);
      check("to_latency", 32'((t1 - t0 >= 16) && (t1 - t0 <= 17)), 32'd1);

      // a byte inside the window restarts the timer
      send(2, 8'h78);
      tick(9);
      send(2, 8'h79);
      tick(12);
      check("to_restart", 32'(wq.size()), 32'd0);
      pull("to_two", 32'h0A007978, t1);

      // source 3 granted last, so round-robin restarts at 0
      send(3, 8'h0A);
      pull("src3_nl", 32'h0D00000A, t0);
      for (int r = 0; r < 2; r++) begin
         for (int b = 1; b <= 3; b++) begin
            for (int s = 0; s < N; s++)
               d[8*s +: 8] = 8'(s * 16 + b + 4 * r);
            drive('1, d);
         end
         for (int s = 0; s < N; s++) begin
            b1 = 8'(s * 16 + 1 + 4 * r);
            b2 = 8'(s * 16 + 2 + 4 * r);
            b3 = 8'(s * 16 + 3 + 4 * r);
            pull($sformatf("rr%0d_s%0d", r, s),
                 {6'(s), 2'd3, b3, b2, b1}, ts[s]);
         end
         for (int s = 1; s < N; s++)
            check($sformatf("rr%0d_gap%0d", r, s), 32'(ts[s] - ts[0]), 32'(s));
      end

      // backpressure holds sealed words
      fifo_almost_full = 1'b1;
      drive(4'b0011, 32'h00000A0A);
      tick(5);
      check("bp_no_write", 32'(wq.size()), 32'd0);
      check("bp_wr_en", 32'(fifo_wr_en), 32'd0);
      check("bp_ready", 32'(src_ready), 32'hC);
      fifo_almost_full = 1'b0;
      pull("bp_w0", 32'h0100000A, t0);
      pull("bp_w1", 32'h0500000A, t1);
      check("bp_gap", 32'(t1 - t0), 32'd1);
      tick(5);
      check("bp_no_dup", 32'(wq.size()), 32'd0);
      check("bp_count", wr_count, 32'd16);
      check("bp_ready_back", 32'(src_ready), 32'hF);

      // reset discards buffered and pending data
      fifo_almost_full = 1'b1;
      send(1, 8'h70);
      send(1, 8'h71);
      send(0, 8'h0A);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check("mid_rst_din", fifo_din, 32'h0);
      check("mid_rst_count", wr_count, 32'h0);
      tick(2);
      rst_n = 1'b1;
      fifo_almost_full = 1'b0;
      tick();
      check("mid_rst_ready", 32'(src_ready), 32'hF);
      tick(30);
      check("mid_rst_no_write", 32'(wq.size()), 32'd0);
      check("mid_rst_count2", wr_count, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
